// File: rtl/sample_rate_gen_pkg.sv
// Shared types and defaults for the audio sample-rate generator.
package audio_clk_pkg;

  // Rate codes as seen on rate_sel / rate_active.
  typedef enum logic [1:0] {
    R11K = 2'd0,
    R22K = 2'd1,
    R44K = 2'd2,
    R48K = 2'd3
  } rate_code_t;

  localparam int unsigned CLK_HZ_DEFAULT = 27_000_000;
  localparam int unsigned RATE0_DEFAULT  = 11_025;
  localparam int unsigned RATE1_DEFAULT  = 22_050;
  localparam int unsigned RATE2_DEFAULT  = 44_100;
  localparam int unsigned RATE3_DEFAULT  = 48_000;
  localparam int unsigned ACC_W_DEFAULT  = 26;

  // Smallest accumulator width that holds acc + inc without overflow.
  function automatic int unsigned acc_width(input longint unsigned clk_hz,
                                            input longint unsigned max_rate);
    return $clog2(clk_hz + 2 * max_rate + 1);
  endfunction

  // Largest of four rates, used for the width check.
  function automatic longint unsigned max4(input longint unsigned a,
                                           input longint unsigned b,
                                           input longint unsigned c,
                                           input longint unsigned d);
    longint unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sample_rate_gen.sv
// Fractional (Bresenham) audio sample-clock generator.
// Each enabled cycle the accumulator gains 2*rate; every time it crosses
// CLK_HZ the output clock toggles, so the long-run rate is exact.
// A new rate code is only taken at a rising edge of clk_out so no
// shortened high or low phase is ever produced.
module sample_rate_gen
  import audio_clk_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned RATE0  = RATE0_DEFAULT,
  parameter int unsigned RATE1  = RATE1_DEFAULT,
  parameter int unsigned RATE2  = RATE2_DEFAULT,
  parameter int unsigned RATE3  = RATE3_DEFAULT,
  parameter int unsigned ACC_W  = ACC_W_DEFAULT
) (
  input  logic       clk_27MHz,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] rate_sel,
  output logic       clk_out,
  output logic       sample_tick,
  output logic [1:0] rate_active,
  output logic       rate_ack
);

  localparam longint unsigned MAX_RATE = max4(RATE0, RATE1, RATE2, RATE3);
  localparam logic [ACC_W-1:0] MOD  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] INC0 = ACC_W'(2 * RATE0);
  localparam logic [ACC_W-1:0] INC1 = ACC_W'(2 * RATE1);
  localparam logic [ACC_W-1:0] INC2 = ACC_W'(2 * RATE2);
  localparam logic [ACC_W-1:0] INC3 = ACC_W'(2 * RATE3);

  // Parameter sanity: every half-period must be at least one cycle and the
  // accumulator must hold acc + inc without wrapping.
  if ((2 * longint'(RATE0) >= longint'(CLK_HZ)) ||
      (2 * longint'(RATE1) >= longint'(CLK_HZ)) ||
      (2 * longint'(RATE2) >= longint'(CLK_HZ)) ||
      (2 * longint'(RATE3) >= longint'(CLK_HZ))) begin : g_bad_rate
    $error("sample_rate_gen: every 2*RATEn must be below CLK_HZ");
  end
  if (ACC_W < acc_width(CLK_HZ, MAX_RATE)) begin : g_bad_width
    $error("sample_rate_gen: ACC_W too small for CLK_HZ + 2*max rate");
  end

  rate_code_t       r_rate_active;
  logic             r_rate_ack;
  logic             r_clk_out;
  logic             r_tick;
  logic [ACC_W-1:0] r_acc;

  rate_code_t       w_rate_req;
  logic [ACC_W-1:0] w_inc;
  logic [ACC_W-1:0] w_sum;
  logic             w_half;
  logic             w_rise;
  logic             w_change;

  assign w_rate_req = rate_code_t'(rate_sel);

  // Constant 4-entry lookup of the per-cycle increment for the active rate.
  always_comb begin
    w_inc = INC0;
    case (r_rate_active)
      R11K: w_inc = INC0;
      R22K: w_inc = INC1;
      R44K: w_inc = INC2;
      R48K: w_inc = INC3;
      default: w_inc = INC0;
    endcase
  end

  // Half-tick detection; a half-tick while clk_out is low is a rising edge.
  always_comb begin
    w_sum    = r_acc + w_inc;
    w_half   = (w_sum >= MOD);
    w_rise   = w_half && !r_clk_out;
    w_change = (w_rate_req != r_rate_active);
  end

  // Accumulator, output clock, strobe and rate-switch register.
  always_ff @(posedge clk_27MHz) begin
    if (reset) begin
      r_acc         <= '0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
      r_rate_active <= w_rate_req;
      r_rate_ack    <= 1'b0;
    end else if (!en) begin
      // Idle: restart from zero and track the requested rate directly.
      r_acc         <= '0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
      r_rate_active <= w_rate_req;
      r_rate_ack    <= w_change;
    end else begin
      r_tick     <= w_rise;
      r_rate_ack <= 1'b0;
      if (w_half) begin
        r_acc     <= w_sum - MOD;
        r_clk_out <= ~r_clk_out;
      end else begin
        r_acc <= w_sum;
      end
      // Rate switch lands together with the tick; acc is kept.
      if (w_rise && w_change) begin
        r_rate_active <= w_rate_req;
        r_rate_ack    <= 1'b1;
      end
    end
  end

  assign clk_out     = r_clk_out;
  assign sample_tick = r_tick;
  assign rate_active = r_rate_active;
  assign rate_ack    = r_rate_ack;

endmodule

// File: tb/tb_sample_rate_gen.sv
// Self-checking bench for sample_rate_gen.
// Expected rising-edge cycles are derived in closed form
// (edge k at ceil((2k-1)*CLK_HZ/inc)) and queued; each sample_tick pops one.
module tb_sample_rate_gen;

  localparam longint CLK_HZ = 27_000_000;
  localparam int     N_RUN  = 15000;

  logic       clk_27MHz;
  logic       reset;
  logic       en;
  logic [1:0] rate_sel;
  logic       clk_out;
  logic       sample_tick;
  logic [1:0] rate_active;
  logic       rate_ack;

  sample_rate_gen dut (
    .clk_27MHz  (clk_27MHz),
    .reset      (reset),
    .en         (en),
    .rate_sel   (rate_sel),
    .clk_out    (clk_out),
    .sample_tick(sample_tick),
    .rate_active(rate_active),
    .rate_ack   (rate_ack)
  );

  // Clock / reset block
  initial clk_27MHz = 1'b0;
  always #5 clk_27MHz = ~clk_27MHz;

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          errors;
  int          checks;
  int          cyc;
  int          ticks;
  int          ack_cyc;
  int          last_edge;
  logic        last_clk;
  bit          phase_chk;
  longint      rates[4];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue expected rising-edge cycles for a run of n cycles at increment inc.
  task automatic push_edges(input longint inc, input int n);
    longint k;
    longint t;
    k = 1;
    t = ((2 * k - 1) * CLK_HZ + inc - 1) / inc;
    while (t <= n) begin
      exp_q.push_back(32'(t));
      k++;
      t = ((2 * k - 1) * CLK_HZ + inc - 1) / inc;
    end
  endtask

  // One clock: sample after the edge and score ticks, acks and phases.
  task automatic step();
    @(posedge clk_27MHz);
    #1;
    cyc++;
    if (sample_tick) begin
      ticks++;
      if (exp_q.size() == 0) check("extra_tick", cyc, 0);
      else check("tick_cyc", cyc, exp_q.pop_front());
    end
    if (rate_ack && en) check("ack_cyc", cyc, ack_cyc);
    if (clk_out !== last_clk) begin
      if (phase_chk) check("phase_ge_306", (cyc - last_edge) >= 306, 1);
      last_edge = cyc;
      last_clk  = clk_out;
    end
  endtask

  // Two-cycle reset with en high; checks reset values.
  task automatic do_reset(input logic [1:0] r);
    rate_sel = r;
    en       = 1'b1;
    reset    = 1'b1;
    @(posedge clk_27MHz); #1;
    @(posedge clk_27MHz); #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_rate_active", rate_active, r);
    check("rst_rate_ack", rate_ack, 0);
    reset     = 1'b0;
    cyc       = 0;
    ticks     = 0;
    last_edge = 0;
    last_clk  = 1'b0;
    ack_cyc   = 0;
    exp_q.delete();
  endtask

  initial begin
    longint inc;
    longint halves;
    errors    = 0;
    checks    = 0;
    phase_chk = 1'b0;
    rates     = '{11025, 22050, 44100, 48000};
    reset     = 1'b1;
    en        = 1'b0;
    rate_sel  = 2'd0;

    // Reset while running: run 22050 past its first rise, then reset.
    do_reset(2'd1);
    push_edges(2 * rates[1], 700);
    repeat (700) step();
    check("pre_rst_ticks", ticks, 1);
    check("pre_rst_clk_high", clk_out, 1);
    do_reset(2'd2);

    // Exactness per rate: tick cycles, total count and final level.
    for (int r = 0; r < 4; r++) begin
      do_reset(2'(r));
      inc = 2 * rates[r];
      push_edges(inc, N_RUN);
      repeat (N_RUN) step();
      halves = (N_RUN * inc) / CLK_HZ;
      check("ticks_missing", exp_q.size(), 0);
      check("tick_total", ticks, (halves + 1) / 2);
      check("end_level", clk_out, halves % 2);
      check("rate_held", rate_active, r);
    end

    // Glitch-free switch 22050 -> 44100 requested mid-period at cycle 900.
    // Ticks at 613 and 1837 (old rate); acc after 1837 is 11700, so with
    // inc 88200 the next rise is 613 cycles later, at 2450.
    do_reset(2'd1);
    phase_chk = 1'b1;
    ack_cyc   = 1837;
    exp_q.push_back(32'd613);
    exp_q.push_back(32'd1837);
    exp_q.push_back(32'd2450);
    repeat (900) step();
    rate_sel = 2'd2;
    while (cyc < 1836) step();
    check("sw_rate_before", rate_active, 1);
    step();
    check("sw_tick_at_switch", sample_tick, 1);
    check("sw_ack_at_switch", rate_ack, 1);
    check("sw_rate_after", rate_active, 2);
    while (cyc < 2460) step();
    check("sw_ticks_missing", exp_q.size(), 0);
    check("sw_tick_total", ticks, 3);
    phase_chk = 1'b0;

    // Enable gating: drop en while clk_out is high, then re-enable.
    do_reset(2'd1);
    exp_q.push_back(32'd613);
    repeat (700) step();
    check("gate_clk_high", clk_out, 1);
    en = 1'b0;
    step();
    check("gate_clk_low", clk_out, 0);
    check("gate_no_tick", sample_tick, 0);
    repeat (20) step();
    check("gate_idle_clk", clk_out, 0);
    en  = 1'b1;
    cyc = 0;
    exp_q.delete();
    exp_q.push_back(32'd613);
    repeat (620) step();
    check("reen_ticks_missing", exp_q.size(), 0);

    // Idle rate change: rate_active follows rate_sel, ack pulses once.
    en       = 1'b0;
    rate_sel = 2'd0;
    repeat (3) step();
    check("idle_rate0", rate_active, 0);
    check("idle_ack_quiet", rate_ack, 0);
    rate_sel = 2'd3;
    step();
    check("idle_rate3", rate_active, 3);
    check("idle_ack_pulse", rate_ack, 1);
    step();
    check("idle_ack_once", rate_ack, 0);
    rate_sel = 2'd0;
    step();
    check("idle_back0", rate_active, 0);
    check("idle_ack_pulse2", rate_ack, 1);
    step();
    check("idle_ack_once2", rate_ack, 0);
    check("idle_clk_low", clk_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_rate_gen.md
Name: sample_rate_gen

Overview:
Parametrised successor to the fixed 22 kHz divider. It derives an audio sample clock from the 27 MHz system clock using an exact fractional (Bresenham) accumulator, so the long-run rate has zero error.
- Four sample rates are selectable at runtime.
- Outputs are a ~50%-duty clk_out and a one-cycle sample_tick strobe.
- It sits between the system clock and the audio playback/DAC path of the jukebox.
- Rate changes are glitch-free: they take effect only at a sample boundary.

Parameters:
CLK_HZ, 27_000_000, input clock frequency; accumulator modulus.
RATE0, 11025, sample rate (Hz) for rate_sel=0.
RATE1, 22050, sample rate (Hz) for rate_sel=1.
RATE2, 44100, sample rate (Hz) for rate_sel=2.
RATE3, 48000, sample rate (Hz) for rate_sel=3.
ACC_W, 26, accumulator width; must satisfy 2^ACC_W > CLK_HZ + 2*max(RATEn).

Ports:
clk_27MHz  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  run enable; low holds the generator idle.
rate_sel  in  2  requested rate code.
clk_out  out  1  sample clock, frequency = selected rate.
sample_tick  out  1  one-cycle strobe coincident with each clk_out rising edge.
rate_active  out  2  rate code currently in use.
rate_ack  out  1  one-cycle pulse when a new rate_sel value is applied.

Behaviour:
- Reset values (reset sampled high at a clock edge): acc=0, clk_out=0, sample_tick=0, rate_ack=0, rate_active=rate_sel.
- Increment: inc = 2*RATE[rate_active], zero-extended to ACC_W.
- Running (en=1), each cycle: sum = acc + inc.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ and clk_out toggles (a "half-tick").
  - Otherwise: acc <= sum.
  - Invariant: acc < CLK_HZ at all times.
- sample_tick is registered and asserts in the same cycle clk_out becomes 1. It never asserts on a falling toggle.
- Exactness: after N enabled cycles from acc=0, half-ticks = floor(N*inc/CLK_HZ) and rising edges = ceil(half-ticks/2). No cumulative drift.
- Latency: the first clk_out rise comes ceil(CLK_HZ/inc) enabled cycles after en rises. For 22050 Hz that is 613 cycles.
- Rate change:
  - While en=1, a rate_sel value differing from rate_active is applied only in the cycle sample_tick asserts. In that cycle rate_active <= rate_sel and rate_ack pulses, and the new inc is used from the next cycle.
  - acc is not cleared on a rate change.
  - If rate_sel changes several times between ticks, only the value present at the tick is applied.
- Idle (en=0):
  - acc <= 0, clk_out <= 0, sample_tick=0.
  - rate_active <= rate_sel each cycle; rate_ack pulses on the cycle the value changes.
- en falling mid-period: clk_out returns low on the next edge with no tick. Re-enabling restarts from acc=0, exactly as after reset.
- reset overrides en and any pending rate change.
- Elaboration checks: 2*RATEn < CLK_HZ for every n, and the ACC_W bound is met; otherwise $error.

Decomposition:
- Package audio_clk_pkg holds:
  - rate_code_t enum: R11K, R22K, R44K, R48K.
  - Default rate constants and CLK_HZ_DEFAULT.
  - Function acc_width(clk_hz, max_rate).
- Implement as a single module. Rate lookup is a 4-entry constant mux; no sub-module is needed.

Test Plan:
- Reset while running: reset for 2 cycles -> acc=0, clk_out=0, sample_tick=0, rate_active equals rate_sel.
- Exactness: rate_sel=1, en=1 for 2,700,000 cycles -> exactly 2205 sample_tick pulses, and the first clk_out rise is at cycle 613.
- Exactness: rate_sel=3, 2,700,000 cycles -> 4800 ticks; rate_sel=2 -> 4410 ticks; rate_sel=0 -> 1102 or 1103 ticks, matching ceil(floor(N*inc/CLK_HZ)/2).
- Glitch-free switch: while running at 22050, change rate_sel to 2 mid-period -> rate_active and rate_ack change only in the next sample_tick cycle; no clk_out high or low phase shorter than 306 cycles before the switch; the post-switch period is 612±1 cycles.
- Enable gating: drop en while clk_out=1 -> clk_out low next cycle, no tick; re-enable -> first rise after ceil(CLK_HZ/inc) cycles.
- Idle rate change: en=0, toggle rate_sel 0->3 -> rate_active follows next cycle and rate_ack pulses once per change.
